spi_master_tx: RTL and testbench
================================

// Module: spi_master_tx
// PURPOSE
//  SPI mode-0 master: serialises a WIDTH-bit word onto mosi MSB-first, generating sclk and cs_n
//  from the system clock, while capturing miso into a parallel receive word.
//  Drives the serial-in / peripheral-clock side of the team's shift register and SPI memory,
//  replacing hand-toggled switches in board and bench tests.
// PARAMETERS
//  WIDTH   8  bits per frame (>=2)
//  CLKDIV  4  Clk cycles per sclk half-period (>=1)
// PORTS
//  Clk      in   1      system clock; all state updates on rising edge
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      request a frame; sampled only when idle
//  txData   in   WIDTH  word to send; captured in the cycle start is accepted
//  miso     in   1      serial data from slave
//  sclk     out  1      serial clock, idle low
//  cs_n     out  1      chip select, active low, idle high
//  mosi     out  1      serial data to slave
//  busy     out  1      high while a frame is in progress
//  done     out  1      one-cycle pulse at frame end
//  rxData   out  WIDTH  received word; valid from done until next accepted start
// BEHAVIOUR
//  Interface: one clock (Clk); reset is asynchronous and active-high.
//  All outputs are registered. Reset (async, any time incl. mid-frame):
//   cs_n=1, sclk=0, mosi=0, busy=0, done=0, rxData=0, state IDLE, counters 0.
//  States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> IDLE.
//   IDLE: cs_n=1, sclk=0. start=1 at edge => next cycle: SETUP, cs_n=0, busy=1,
//    mosi=txData[WIDTH-1], tx shift reg loaded, bit counter=0. start=0 => stay.
//   SETUP: sclk=0 for CLKDIV cycles, then sclk=1, -> SHIFT_HI.
//   SHIFT_HI: sclk=1 for CLKDIV cycles. In the cycle sclk rises, miso is sampled into the
//    rx shift reg LSB (shift left). After CLKDIV cycles sclk=0, -> SHIFT_LO; on this
//    falling edge mosi advances to the next bit if bit counter < WIDTH-1.
//   SHIFT_LO: sclk=0 for CLKDIV cycles. If bit counter < WIDTH-1: increment, sclk=1,
//    -> SHIFT_HI. Else (last low phase = hold time): cs_n=1, busy=0, done=1,
//    rxData<=rx shift reg, mosi=0, -> IDLE.
//  Timing: exactly WIDTH rising sclk edges per frame; cs_n low for CLKDIV*(2*WIDTH+1) cycles;
//   done asserts CLKDIV*(2*WIDTH+1)+1 cycles after the start-accept edge (WIDTH=8,CLKDIV=4: 69).
//  mosi stable >=CLKDIV cycles before and after each rising sclk edge.
//  start while busy: ignored, no queueing; txData changes while busy have no effect.
//  Back-to-back: start high in the done cycle is accepted; cs_n high exactly 1 cycle between frames.
//  done and busy never high in the same cycle. Counters sized $clog2(CLKDIV), $clog2(WIDTH);
//   half-period counter resets to 0 at every phase change, no wrap beyond CLKDIV-1.
// TESTING (WIDTH=8, CLKDIV=4 unless noted)
//  1 Assert reset mid-idle and mid-frame -> all outputs at reset values same cycle, no glitch frame.
//  2 txData=8'hA5, miso looped to mosi, pulse start -> mosi at 8 sclk rises = 1,0,1,0,0,1,0,1;
//    done 69 cycles after accept; rxData=8'hA5; cs_n low 68 cycles.
//  3 txData=8'h00, miso=1 -> mosi 0 throughout, rxData=8'hFF; then txData=8'hFF, miso=0 -> rxData=8'h00.
//  4 Frame with 8'h3C; at cycle 20 pulse start with txData=8'hC3 -> ignored: one frame only, 8 rises, mosi pattern of 8'h3C.
//  5 reset at 4th sclk rise, release, start with 8'h5A (loopback) -> complete frame, rxData=8'h5A.
//  6 start held high, CLKDIV=1, txData 8'h81 -> frames repeat; cs_n high exactly 1 cycle between, each done 18 cycles apart.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts a WIDTH-bit word out on mosi MSB-first while capturing miso,
// with sclk and cs_n derived from Clk by a CLKDIV-cycle half-period counter.
module spi_master_tx #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txData,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rxData
);

  localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO} state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    half_q, half_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = txData[WIDTH-1];
          tx_d    = txData;
          rx_d    = '0;
          bit_d   = '0;
          half_d  = '0;
        end
      end

      SETUP: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], miso};
          state_d = SHIFT_HI;
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT_LO;
          // Next bit goes out on the falling edge so it is settled a full half-period before the rise.
          if (bit_q < BIT_LAST) begin
            tx_d   = tx_q << 1;
            mosi_d = tx_q[WIDTH-2];
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      SHIFT_LO: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bit_q < BIT_LAST) begin
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b1;
            rx_d    = {rx_q[WIDTH-2:0], miso};
            state_d = SHIFT_HI;
          end else begin
            // Final low phase is the hold time after the last rise; frame ends here.
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_q;
            mosi_d    = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sclk   = sclk_q;
  assign cs_n   = cs_n_q;
  assign mosi   = mosi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rxData = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed + randomized bench for spi_master_tx: frame-level model of bit order,
// frame timing, received word and reset behaviour; second instance with CLKDIV=1 for back-to-back.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tx_a = 8'h00, tx_b = 8'h00;
  logic       miso_drv = 1'b0, loop_a = 1'b0;
  logic       miso_a, miso_b;
  logic       sclk_a, cs_n_a, mosi_a, busy_a, done_a;
  logic       sclk_b, cs_n_b, mosi_b, busy_b, done_b;
  logic [7:0] rx_a, rx_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign miso_a = loop_a ? mosi_a : miso_drv;
  assign miso_b = mosi_b;

  spi_master_tx #(.WIDTH(8), .CLKDIV(4)) dut_a (
    .Clk(clk), .reset(rst), .start(start_a), .txData(tx_a), .miso(miso_a),
    .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .busy(busy_a), .done(done_a), .rxData(rx_a)
  );

  spi_master_tx #(.WIDTH(8), .CLKDIV(1)) dut_b (
    .Clk(clk), .reset(rst), .start(start_b), .txData(tx_b), .miso(miso_b),
    .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .busy(busy_b), .done(done_b), .rxData(rx_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs of instance A packed as {cs_n, sclk, mosi, busy, done, rxData}.
  function automatic logic [12:0] outs_a();
    return {cs_n_a, sclk_a, mosi_a, busy_a, done_a, rx_a};
  endfunction

  task automatic reset_now(input string tag);
    #2 rst = 1'b1;
    #1 check(tag, 32'(outs_a()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic no_glitch(input string tag);
    int low = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cs_n_a == 1'b0 || busy_a) low++;
    end
    check(tag, 32'(low), 32'd0);
  endtask

  // One frame on instance A. miso_mode: 0 loopback, 1 constant miso_val, 2 random.
  // inject_cyc>0 pulses a second start (with txData=C3) mid-frame; abort_rise>0 resets after that rise.
  task automatic frame(input string tag, input logic [7:0] tx, input int miso_mode,
                       input logic miso_val, input int inject_cyc, input int abort_rise);
    logic [7:0] mosi_seen = 8'h00;
    logic [7:0] miso_seen = 8'h00;
    logic       prev_sclk = 1'b0;
    int rises = 0, low = 0, done_cyc = -1, overlap = 0;
    loop_a   = (miso_mode == 0);
    miso_drv = miso_val;
    @(negedge clk);
    tx_a    = tx;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_a = 1'b0;
        check({tag, " first cycle"}, 32'({cs_n_a, busy_a, mosi_a}), 32'({1'b0, 1'b1, tx[7]}));
      end
      if (cs_n_a == 1'b0) low++;
      if (busy_a && done_a) overlap++;
      if (sclk_a && !prev_sclk) begin
        rises++;
        mosi_seen = {mosi_seen[6:0], mosi_a};
        miso_seen = {miso_seen[6:0], miso_a};
        if (rises == abort_rise) begin
          reset_now({tag, " reset mid-frame"});
          return;
        end
      end
      prev_sclk = sclk_a;
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      if (miso_mode == 2) miso_drv = 1'($urandom_range(0, 1));
      if (inject_cyc > 0 && cyc == inject_cyc) begin
        start_a = 1'b1;
        tx_a    = 8'hC3;
      end
      if (inject_cyc > 0 && cyc == inject_cyc + 1) start_a = 1'b0;
    end
    start_a = 1'b0;
    check({tag, " done latency"}, 32'(done_cyc), 32'd69);
    check({tag, " cs_n low cycles"}, 32'(low), 32'd68);
    check({tag, " sclk rises"}, 32'(rises), 32'd8);
    check({tag, " mosi bits"}, 32'(mosi_seen), 32'(tx));
    check({tag, " rxData"}, 32'(rx_a), 32'(miso_mode == 0 ? tx : miso_seen));
    check({tag, " busy/done overlap"}, 32'(overlap), 32'd0);
    $display("[TB] %s tx=%02h rx=%02h done@%0d rises=%0d", tag, tx, rx_a, done_cyc, rises);
  endtask

  initial begin
    logic [7:0] r;
    int last_done, dcount, hi_run, frames_seen, seen_low;

    // Reset state while reset is held.
    repeat (3) @(negedge clk);
    check("reset held", 32'(outs_a()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-idle, then mid-frame.
    reset_now("reset idle");
    no_glitch("idle reset no frame");
    frame("mid-frame", 8'h96, 0, 1'b0, 0, 2);
    no_glitch("mid-frame reset no frame");

    frame("loop A5", 8'hA5, 0, 1'b0, 0, 0);
    frame("zeros miso=1", 8'h00, 1, 1'b1, 0, 0);
    check("rxData FF", 32'(rx_a), 32'h0000_00FF);
    frame("ones miso=0", 8'hFF, 1, 1'b0, 0, 0);
    check("rxData 00", 32'(rx_a), 32'h0000_0000);

    frame("ignore start", 8'h3C, 0, 1'b0, 20, 0);
    no_glitch("no queued frame");

    frame("abort at rise 4", 8'hE7, 0, 1'b0, 0, 4);
    check("rxData cleared", 32'(rx_a), 32'h0000_0000);
    frame("after reset 5A", 8'h5A, 0, 1'b0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      frame("random", r, (i % 2 == 0) ? 2 : 0, 1'($urandom_range(0, 1)), 0, 0);
    end

    // Back-to-back frames with start held high, CLKDIV=1.
    tx_b = 8'h81;
    start_b = 1'b1;
    last_done = -1; dcount = 0; hi_run = 0; frames_seen = 0; seen_low = 0;
    for (int cyc = 0; cyc < 80 && dcount < 4; cyc++) begin
      @(negedge clk);
      if (cs_n_b) begin
        hi_run++;
      end else begin
        if (seen_low != 0 && hi_run != 0) begin
          check("b2b cs_n high gap", 32'(hi_run), 32'd1);
          frames_seen++;
        end
        seen_low = 1;
        hi_run = 0;
      end
      if (done_b) begin
        check("b2b rxData", 32'(rx_b), 32'h0000_0081);
        if (last_done >= 0) check("b2b done spacing", 32'(cyc - last_done), 32'd18);
        $display("[TB] b2b done at cycle %0d rx=%02h", cyc, rx_b);
        last_done = cyc;
        dcount++;
      end
    end
    start_b = 1'b0;
    check("b2b done count", 32'(dcount), 32'd4);
    check("b2b gaps seen", 32'(frames_seen >= 3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
